// File: rtl/fpu_norm_pkg.sv
// Shared types and constants for the FP add/sub normalizer.
// The S1 bundle is sized for the default datapath (26-bit significand, 8-bit exponent).
package fpu_norm_pkg;

   localparam int PKG_SWR = 26;
   localparam int PKG_EWR = 8;

   // Width needed to hold a leading-zero count in the range 0..swr.
   function automatic int lzw_f(input int swr);
      return $clog2(swr + 1);
   endfunction

   localparam int PKG_LZW = lzw_f(PKG_SWR);

   // All-ones biased exponent encodes infinity.
   localparam logic [PKG_EWR-1:0] EXP_MAX = '1;

   // Everything stage 1 hands to stage 2.
   typedef struct packed {
      logic [PKG_SWR-1:0] sgf;
      logic               carry;
      logic [PKG_EWR-1:0] exp;
      logic [PKG_LZW-1:0] lz;
      logic               valid;
   } s1_t;

endpackage

// File: rtl/norm_shift_unit_if.sv
// Data/flag bundle between the significand adder, the normalizer and rounding.
interface norm_shift_unit_if #(
   parameter int SWR = 26,
   parameter int EWR = 8
);
   logic           valid_i;
   logic           stall_i;
   logic [SWR-1:0] sgf_i;
   logic           carry_i;
   logic [EWR-1:0] exp_i;
   logic           valid_o;
   logic [SWR-1:0] sgf_o;
   logic [EWR-1:0] exp_o;
   logic           zero_o;
   logic           underflow_o;
   logic           overflow_o;

   // Upstream/testbench side: drives operands, observes results.
   modport master (
      output valid_i, stall_i, sgf_i, carry_i, exp_i,
      input  valid_o, sgf_o, exp_o, zero_o, underflow_o, overflow_o
   );

   // Normalizer side.
   modport slave (
      input  valid_i, stall_i, sgf_i, carry_i, exp_i,
      output valid_o, sgf_o, exp_o, zero_o, underflow_o, overflow_o
   );
endinterface

// File: rtl/lzd_counter.sv
// Combinational leading-zero counter; returns SWR for an all-zero input.
module lzd_counter
   import fpu_norm_pkg::*;
#(
   parameter int SWR = 26
) (
   input  logic [SWR-1:0]          sgf,
   output logic [lzw_f(SWR)-1:0]   lz
);
   localparam int LZW = lzw_f(SWR);

   // Scan LSB to MSB so the highest set bit is the last one to win.
   always_comb begin
      lz = LZW'(SWR);
      for (int i = 0; i < SWR; i++) begin
         if (sgf[i]) begin
            lz = LZW'(SWR - 1 - i);
         end
      end
   end
endmodule

// File: rtl/norm_shift_unit.sv
// Two-stage normalizer: S1 registers the sum plus its leading-zero count,
// S2 shifts/adjusts the exponent and raises zero/underflow/overflow.
module norm_shift_unit
   import fpu_norm_pkg::*;
#(
   parameter int SWR = PKG_SWR,
   parameter int EWR = PKG_EWR
) (
   input logic              clk,
   input logic              rst,
   norm_shift_unit_if.slave bus
);
   localparam int LZW = lzw_f(SWR);

   s1_t             s1_reg;
   logic [LZW-1:0]  lz;

   logic            valid_reg;
   logic [SWR-1:0]  sgf_reg;
   logic [EWR-1:0]  exp_reg;
   logic            zero_reg;
   logic            underflow_reg;
   logic            overflow_reg;

   logic [SWR-1:0]  sgf_next;
   logic [EWR-1:0]  exp_next;
   logic            zero_next;
   logic            underflow_next;
   logic            overflow_next;

   // One guard bit on the exponent so exp-lz and exp+1 never wrap.
   logic [EWR:0]    exp_ext;
   logic [EWR:0]    lz_ext;
   logic [EWR:0]    exp_inc;
   logic [EWR:0]    exp_sub;

   lzd_counter #(.SWR(SWR)) u_lzd (
      .sgf (bus.sgf_i),
      .lz  (lz)
   );

   // S1: capture operand and its lz; valid advances whenever not stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_reg <= '0;
      end else if (!bus.stall_i) begin
         s1_reg.valid <= bus.valid_i;
         if (bus.valid_i) begin
            s1_reg.sgf   <= bus.sgf_i;
            s1_reg.carry <= bus.carry_i;
            s1_reg.exp   <= bus.exp_i;
            s1_reg.lz    <= lz;
         end
      end
   end

   assign exp_ext = {1'b0, s1_reg.exp};
   assign lz_ext  = (EWR+1)'(s1_reg.lz);
   assign exp_inc = exp_ext + 1'b1;
   assign exp_sub = exp_ext - lz_ext;

   // S2 result selection: carry, then exact zero, then underflow, then normal shift.
   always_comb begin
      sgf_next       = '0;
      exp_next       = '0;
      zero_next      = 1'b0;
      underflow_next = 1'b0;
      overflow_next  = 1'b0;
      if (s1_reg.carry) begin
         exp_next = exp_inc[EWR-1:0];
         if (exp_inc == {1'b0, EXP_MAX}) begin
            overflow_next = 1'b1;
         end else begin
            sgf_next = {1'b1, s1_reg.sgf[SWR-1:2], s1_reg.sgf[1] | s1_reg.sgf[0]};
         end
      end else if (s1_reg.lz == LZW'(SWR)) begin
         zero_next = 1'b1;
      end else if (lz_ext >= exp_ext) begin
         // Normalizing would exhaust the exponent: flush to zero.
         zero_next      = 1'b1;
         underflow_next = 1'b1;
      end else begin
         sgf_next = s1_reg.sgf << s1_reg.lz;
         exp_next = exp_sub[EWR-1:0];
      end
   end

   // S2 output registers hold the last valid result across bubbles and stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg     <= 1'b0;
         sgf_reg       <= '0;
         exp_reg       <= '0;
         zero_reg      <= 1'b0;
         underflow_reg <= 1'b0;
         overflow_reg  <= 1'b0;
      end else if (!bus.stall_i) begin
         valid_reg <= s1_reg.valid;
         if (s1_reg.valid) begin
            sgf_reg       <= sgf_next;
            exp_reg       <= exp_next;
            zero_reg      <= zero_next;
            underflow_reg <= underflow_next;
            overflow_reg  <= overflow_next;
         end
      end
   end

   assign bus.valid_o     = valid_reg;
   assign bus.sgf_o       = sgf_reg;
   assign bus.exp_o       = exp_reg;
   assign bus.zero_o      = zero_reg;
   assign bus.underflow_o = underflow_reg;
   assign bus.overflow_o  = overflow_reg;
endmodule

// File: tb/tb_norm_shift_unit.sv
// Scoreboard bench for norm_shift_unit: the driver queues hand-computed
// results, the monitor pops one per fresh output and checks value and latency.
module tb_norm_shift_unit;
   localparam int SWR = 26;
   localparam int EWR = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   norm_shift_unit_if #(.SWR(SWR), .EWR(EWR)) bus ();

   norm_shift_unit #(.SWR(SWR), .EWR(EWR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string          name;
      logic [SWR-1:0] sgf;
      logic [EWR-1:0] exp;
      logic           zero;
      logic           uf;
      logic           of;
      int             adv;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   adv = 0;
   bit   edge_adv = 1'b0;
   bit   edge_stall = 1'b0;
   logic prev_valid = 1'b0;

   // Count pipeline-advancing edges; a result is due two advances after acceptance.
   always @(posedge clk) begin
      edge_adv   <= !rst && !bus.stall_i;
      edge_stall <= !rst && bus.stall_i;
      if (!rst && !bus.stall_i) adv <= adv + 1;
   end

   // Monitor: check stall freeze and pop/compare each freshly produced result.
   always @(negedge clk) begin
      exp_t e;
      if (edge_stall) begin
         n_cmp++;
         if (bus.valid_o !== prev_valid) begin
            n_err++;
            $display("FAIL stall_freeze: valid_o=%b, required %b", bus.valid_o, prev_valid);
         end
      end
      if (edge_adv && bus.valid_o === 1'b1) begin
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: sgf=%h exp=%0d with empty scoreboard", bus.sgf_o, bus.exp_o);
         end else begin
            e = sb_q.pop_front();
            if (bus.sgf_o !== e.sgf || bus.exp_o !== e.exp || bus.zero_o !== e.zero ||
                bus.underflow_o !== e.uf || bus.overflow_o !== e.of) begin
               n_err++;
               $display("FAIL %s: got sgf=%h exp=%0d z=%b u=%b o=%b, required sgf=%h exp=%0d z=%b u=%b o=%b",
                        e.name, bus.sgf_o, bus.exp_o, bus.zero_o, bus.underflow_o, bus.overflow_o,
                        e.sgf, e.exp, e.zero, e.uf, e.of);
            end else begin
               $display("ok   %s: sgf=%h exp=%0d z=%b u=%b o=%b", e.name, bus.sgf_o, bus.exp_o,
                        bus.zero_o, bus.underflow_o, bus.overflow_o);
            end
            n_cmp++;
            if (adv !== e.adv) begin
               n_err++;
               $display("FAIL %s latency: arrived at advance %0d, required %0d", e.name, adv, e.adv);
            end
         end
      end
      prev_valid = bus.valid_o;
   end

   task automatic drive(input logic v, input logic [SWR-1:0] s, input logic c,
                        input logic [EWR-1:0] e, input logic st);
      bus.valid_i = v;
      bus.sgf_i   = s;
      bus.carry_i = c;
      bus.exp_i   = e;
      bus.stall_i = st;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input string name, input logic [SWR-1:0] s, input logic c,
                       input logic [EWR-1:0] e, input logic [SWR-1:0] xs,
                       input logic [EWR-1:0] xe, input logic xz, input logic xu, input logic xo);
      exp_t t;
      t.name = name; t.sgf = xs; t.exp = xe; t.zero = xz; t.uf = xu; t.of = xo;
      t.adv  = adv + 2;
      sb_q.push_back(t);
      drive(1'b1, s, c, e, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic check_reset(input string name);
      n_cmp++;
      if ({bus.valid_o, bus.sgf_o, bus.exp_o, bus.zero_o, bus.underflow_o, bus.overflow_o} !== '0) begin
         n_err++;
         $display("FAIL %s: valid=%b sgf=%h exp=%0d z=%b u=%b o=%b, required all 0", name,
                  bus.valid_o, bus.sgf_o, bus.exp_o, bus.zero_o, bus.underflow_o, bus.overflow_o);
      end else begin
         $display("ok   %s: all outputs 0", name);
      end
   endtask

   initial begin
      bus.valid_i = 1'b0;
      bus.stall_i = 1'b0;
      bus.sgf_i   = '0;
      bus.carry_i = 1'b0;
      bus.exp_i   = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset("reset_state");
      rst = 1'b0;

      //    name            sgf_i        c  exp_i  sgf_o        exp_o z  u  o
      send("passthrough",  26'h2000000, 1'b0, 8'd127, 26'h2000000, 8'd127, 1'b0, 1'b0, 1'b0);
      send("carry_shift",  26'h0000003, 1'b1, 8'd127, 26'h2000001, 8'd128, 1'b0, 1'b0, 1'b0);
      send("carry_ovf",    26'h0000003, 1'b1, 8'd254, 26'h0000000, 8'd255, 1'b0, 1'b0, 1'b1);
      send("carry_253",    26'h3FFFFFF, 1'b1, 8'd253, 26'h3FFFFFF, 8'd254, 1'b0, 1'b0, 1'b0);
      send("left_norm",    26'h0000100, 1'b0, 8'd127, 26'h2000000, 8'd110, 1'b0, 1'b0, 1'b0);
      send("left_uflow",   26'h0000100, 1'b0, 8'd10,  26'h0000000, 8'd0,   1'b1, 1'b1, 1'b0);
      send("zero",         26'h0000000, 1'b0, 8'd90,  26'h0000000, 8'd0,   1'b1, 1'b0, 1'b0);
      send("lz25_exp26",   26'h0000001, 1'b0, 8'd26,  26'h2000000, 8'd1,   1'b0, 1'b0, 1'b0);
      send("lz_eq_exp",    26'h0000001, 1'b0, 8'd25,  26'h0000000, 8'd0,   1'b1, 1'b1, 1'b0);
      idle(4);

      // Stall: B is held on the inputs through three stalled cycles and accepted once.
      send("stall_a",      26'h2000000, 1'b0, 8'd127, 26'h2000000, 8'd127, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 26'h0000100, 1'b0, 8'd127, 1'b1);
      send("stall_b",      26'h0000100, 1'b0, 8'd127, 26'h2000000, 8'd110, 1'b0, 1'b0, 1'b0);
      send("stall_c",      26'h0000003, 1'b1, 8'd127, 26'h2000001, 8'd128, 1'b0, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      idle(4);

      // Reset mid-flight while stalled: the victim must never emerge.
      send("rst_victim",   26'h0000100, 1'b0, 8'd127, 26'h2000000, 8'd110, 1'b0, 1'b0, 1'b0);
      sb_q.delete();
      rst = 1'b1;
      drive(1'b1, 26'h0000003, 1'b1, 8'd127, 1'b1);
      check_reset("reset_midflight");
      rst = 1'b0;
      send("post_reset",   26'h2000000, 1'b0, 8'd50,  26'h2000000, 8'd50,  1'b0, 1'b0, 1'b0);
      idle(4);

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) idle(1);
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d results outstanding, required 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
